sram_stream_reader: RTL
=======================

// Module: sram_stream_reader
// PURPOSE
//  Read-side master for the dual-port SRAM buffer (1-cycle registered read port: enb/addrb -> doutb).
//  Accepts a (start address, beat count) command, issues SRAM reads, and emits the words
//  as a valid/ready stream with a last flag. Hides the SRAM read latency with a 2-entry output FIFO.
//  Sits between the SRAM read port and the NPU datapath consumer.
// PARAMETERS
//  ADDR_W  12   SRAM word address width (4096 words)
//  DATA_W  128  SRAM word / stream data width
//  LEN_W   13   command length width; holds 0..4096 beats
// PORTS
//  clk        in   1       single clock; also drives the SRAM read clock (clkb)
//  rst        in   1       synchronous, active-high reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       high only in IDLE
//  cmd_addr   in   ADDR_W  first word address
//  cmd_len    in   LEN_W   number of words to read
//  sram_en    out  1       to SRAM enb; one read per high cycle
//  sram_addr  out  ADDR_W  to SRAM addrb
//  sram_dout  in   DATA_W  from SRAM doutb; valid the cycle after sram_en
//  m_valid    out  1       stream data valid
//  m_ready    in   1       stream consumer ready
//  m_data     out  DATA_W  stream word
//  m_last     out  1       high with the final beat of the command
//  done       out  1       1-cycle pulse after the final beat handshake (or a zero-length command)
//  busy       out  1       high when not IDLE
// BEHAVIOUR
//  Reset: cmd_ready=0 during rst, then 1; sram_en=0; sram_addr=0; m_valid=0; m_last=0; done=0;
//   busy=0; FIFO emptied; in-flight read flag cleared. Reset mid-command discards all state. Data
//   returned by a read issued before reset is never captured.
//  FSM: IDLE -> READ on cmd_valid&cmd_ready with cmd_len!=0. IDLE stays IDLE on cmd_len==0; done
//   pulses the next cycle and no read is issued. READ -> DRAIN when the last read is issued.
//   DRAIN -> IDLE on the m_last handshake; done pulses in the cycle after that handshake.
//  Issue rule: in READ, sram_en=1 iff remaining>0 and (fifo_count + inflight - pop) < 2, where
//   pop = m_valid&m_ready in that cycle. This gives sustained 1 beat/cycle when m_ready is held
//   high, and the FIFO never overflows.
//  Addressing: the first read uses cmd_addr. The address increments by 1 per issued read, modulo
//   2^ADDR_W; 0xFFF wraps to 0x000. sram_addr may hold any value while sram_en=0.
//  Capture: the inflight flag is set on the cycle sram_en=1. The next cycle, sram_dout is written
//   into the FIFO. Capture only ever happens through the inflight flag.
//  Latency: command accepted at edge E0 -> sram_en high in cycle 1 -> data captured at E2 ->
//   m_valid high in cycle 3.
//  Stream: m_data/m_last are held stable while m_valid&!m_ready (AXI-style; no retraction).
//   m_last is tagged on the word from the final issued read.
//  Simultaneous events: the FIFO accepts a push and a pop in the same cycle. cmd_valid is ignored
//   outside IDLE. The next command can be accepted in the cycle after done.
//  Length: cmd_len = 4096 reads the full array once. Values above 4096 are not supported
//   (behaviour undefined).
// TESTING
//  T1 addr=0x010 len=4, m_ready=1 -> sram_addr 0x010..0x013 on 4 consecutive sram_en cycles;
//     first m_valid 3 cycles after accept; 4 beats, m_last on beat 4; done once.
//  T2 addr=0xFFE len=4 -> reads 0xFFE,0xFFF,0x000,0x001; data matches SRAM model.
//  T3 len=8, m_ready toggling/random 30% -> no lost/duplicated beats; data stable while stalled;
//     sram_en never high with FIFO+inflight full.
//  T4 len=0 -> no sram_en, no m_valid, done pulse 1 cycle after accept.
//  T5 rst asserted mid-command (after 3 beats of len=16) -> all outputs at reset values next
//     cycle; a new len=2 command yields exactly 2 correct beats.
//  T6 cmd_valid held high across two commands -> second accepted only after first done;
//     back-to-back data correct.

Source files
------------

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: command-driven read master for a 1-cycle registered SRAM
// read port. It turns (addr, len) into a valid/ready word stream with a last flag,
// and uses a 2-entry FIFO to hide the read latency.
module sram_stream_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   remaining;
    logic               inflight;
    logic               inflight_last;
    logic               done_set;
    logic               accept;
    logic               pop;
    logic               can_issue;
    logic [2:0]         occupancy;

    logic [DATA_W-1:0]  fifo_data [2];
    logic               fifo_last [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         fifo_count;

    assign m_valid   = (fifo_count != 2'd0);
    assign m_data    = fifo_data[rd_ptr];
    assign m_last    = m_valid & fifo_last[rd_ptr];
    assign pop       = m_valid & m_ready;
    assign sram_addr = addr_q;
    assign busy      = (state != S_IDLE);

    // Words held or on their way: a read may issue only if, after this cycle's pop,
    // fewer than two slots are committed.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    assign can_issue = (occupancy < (3'd2 + {2'b00, pop}));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, read issue, command handshake and completion decode
    always_comb begin
        state_next = state;
        sram_en    = 1'b0;
        done_set   = 1'b0;
        cmd_ready  = (state == S_IDLE) && !rst;
        accept     = cmd_valid && cmd_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_len != '0) begin
                        state_next = S_READ;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            S_READ: begin
                if ((remaining != '0) && can_issue) begin
                    sram_en = 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_next = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Address/length tracking, in-flight read flag, FIFO pointers and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            done          <= 1'b0;
        end else begin
            done <= done_set;
            if (accept) begin
                addr_q    <= cmd_addr;
                remaining <= cmd_len;
            end else if (sram_en) begin
                addr_q    <= addr_q + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            inflight      <= sram_en;
            inflight_last <= sram_en && (remaining == LEN_W'(1));
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // FIFO storage; written only from the in-flight read, so no reset is needed
    always_ff @(posedge clk) begin
        if (!rst && inflight) begin
            fifo_data[wr_ptr] <= sram_dout;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end

endmodule
